// File: rtl/simdma_init_seq.sv
// Init-ROM walker: streams NOP/WRITE/END records from a synchronous ROM into a valid/ready write port.
// SIMDMA_INIT_CHKSUM_EN adds a trailing XOR checksum word check after END.

package simdma_init_pkg;
  typedef struct packed {
    logic clk;
  } iu_clk_type;
endpackage

module simdma_init_seq
  import simdma_init_pkg::*;
(
  input  iu_clk_type  gclk,
  input  logic        rst,
  input  logic        start,
  output logic [15:0] rom_addr,
  input  logic [31:0] rom_dout,
  output logic        wr_valid,
  output logic [31:0] wr_addr,
  output logic [31:0] wr_data,
  input  logic        wr_ready,
  output logic        busy,
  output logic        done,
  output logic        err
);

  typedef enum logic [3:0] {
    S_IDLE, S_FETCH, S_HDR, S_BASE, S_DATA, S_WAIT_WR, S_CHK, S_DONE, S_ERR
  } state_t;

  localparam logic [3:0] OP_NOP   = 4'h0;
  localparam logic [3:0] OP_WRITE = 4'h1;
  localparam logic [3:0] OP_END   = 4'hF;

  state_t      state_q, state_d;
  logic [13:0] idx_q, idx_d;
  logic        rd_vld_q, rd_vld_d;
  logic        hold_vld_q, hold_vld_d;
  logic [31:0] hold_q, hold_d;
  logic        ovr_q, ovr_d;
  logic [15:0] rem_q, rem_d;
  logic        wr_valid_q, wr_valid_d;
  logic [31:0] wr_addr_q, wr_addr_d;
  logic [31:0] wr_data_q, wr_data_d;
  logic        busy_q, busy_d;
  logic        done_q, done_d;
  logic        err_q, err_d;
`ifdef SIMDMA_INIT_CHKSUM_EN
  logic [31:0] chk_q, chk_d;
`endif

  logic [31:0] word;
  logic [15:0] rem_dec;
  logic        consume, last, issue;

  // idx_q is the word index on the ROM address bus; bit 13 flags the fetch past the last word
  always_comb begin
    state_d    = state_q;
    idx_d      = idx_q;
    hold_vld_d = hold_vld_q;
    hold_d     = hold_q;
    ovr_d      = ovr_q;
    rem_d      = rem_q;
    wr_valid_d = wr_valid_q;
    wr_addr_d  = wr_addr_q;
    wr_data_d  = wr_data_q;
    busy_d     = busy_q;
    done_d     = done_q;
    err_d      = err_q;
`ifdef SIMDMA_INIT_CHKSUM_EN
    chk_d      = chk_q;
`endif
    consume    = 1'b0;
    last       = 1'b0;
    word       = hold_vld_q ? hold_q : rom_dout;
    rem_dec    = rem_q - 16'd1;

    case (state_q)
      S_IDLE: begin
        idx_d = '0;
        ovr_d = 1'b0;
        if (start) begin
          state_d = S_FETCH;
          busy_d  = 1'b1;
          done_d  = 1'b0;
          err_d   = 1'b0;
`ifdef SIMDMA_INIT_CHKSUM_EN
          chk_d   = '0;
`endif
        end
      end
      S_FETCH: state_d = S_HDR;
      S_HDR: begin
        consume = 1'b1;
        if (ovr_q) begin
          last    = 1'b1;
          state_d = S_ERR;
        end else begin
          case (word[31:28])
            OP_NOP:   state_d = S_HDR;
            OP_WRITE: begin
              rem_d   = word[15:0];
              state_d = S_BASE;
            end
`ifdef SIMDMA_INIT_CHKSUM_EN
            OP_END:   state_d = S_CHK;
`else
            OP_END: begin
              last    = 1'b1;
              state_d = S_DONE;
            end
`endif
            default: begin
              last    = 1'b1;
              state_d = S_ERR;
            end
          endcase
        end
      end
      S_BASE: begin
        consume = 1'b1;
        if (ovr_q) begin
          last    = 1'b1;
          state_d = S_ERR;
        end else begin
          wr_addr_d = word;
          state_d   = (rem_q == 16'd0) ? S_HDR : S_DATA;
        end
      end
      S_DATA: begin
        consume = 1'b1;
        if (ovr_q) begin
          last    = 1'b1;
          state_d = S_ERR;
        end else begin
          wr_data_d  = word;
          wr_valid_d = 1'b1;
          state_d    = S_WAIT_WR;
        end
      end
      S_WAIT_WR: begin
        if (wr_ready) begin
          rem_d = rem_dec;
          if (rem_dec == 16'd0) begin
            wr_valid_d = 1'b0;
            state_d    = S_HDR;
          end else begin
            consume = 1'b1;
            if (ovr_q) begin
              last       = 1'b1;
              wr_valid_d = 1'b0;
              state_d    = S_ERR;
            end else begin
              wr_addr_d = wr_addr_q + 32'd4;
              wr_data_d = word;
            end
          end
        end
      end
`ifdef SIMDMA_INIT_CHKSUM_EN
      S_CHK: begin
        consume = 1'b1;
        last    = 1'b1;
        state_d = (!ovr_q && word == chk_q) ? S_DONE : S_ERR;
      end
`endif
      S_DONE: begin
        busy_d     = 1'b0;
        done_d     = 1'b1;
        wr_valid_d = 1'b0;
        state_d    = S_IDLE;
      end
      S_ERR: begin
        busy_d     = 1'b0;
        err_d      = 1'b1;
        wr_valid_d = 1'b0;
        state_d    = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase

    // One read in flight at most: a new address is issued only when the current word is used
    issue = (state_q == S_FETCH) || (consume && !last);
    if (issue) begin
      idx_d = idx_q + {13'd0, ~idx_q[13]};
      ovr_d = idx_q[13];
    end
    rd_vld_d = issue;

    if (consume) begin
      hold_vld_d = 1'b0;
    end else if (rd_vld_q) begin
      hold_vld_d = 1'b1;
      hold_d     = rom_dout;
    end

`ifdef SIMDMA_INIT_CHKSUM_EN
    if (consume && state_q != S_CHK) chk_d = chk_q ^ word;
`endif
  end

  always_ff @(posedge gclk.clk or posedge rst) begin
    if (rst) begin
      state_q    <= S_IDLE;
      idx_q      <= '0;
      rd_vld_q   <= 1'b0;
      hold_vld_q <= 1'b0;
      hold_q     <= '0;
      ovr_q      <= 1'b0;
      rem_q      <= '0;
      wr_valid_q <= 1'b0;
      wr_addr_q  <= '0;
      wr_data_q  <= '0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      err_q      <= 1'b0;
`ifdef SIMDMA_INIT_CHKSUM_EN
      chk_q      <= '0;
`endif
    end else begin
      state_q    <= state_d;
      idx_q      <= idx_d;
      rd_vld_q   <= rd_vld_d;
      hold_vld_q <= hold_vld_d;
      hold_q     <= hold_d;
      ovr_q      <= ovr_d;
      rem_q      <= rem_d;
      wr_valid_q <= wr_valid_d;
      wr_addr_q  <= wr_addr_d;
      wr_data_q  <= wr_data_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
      err_q      <= err_d;
`ifdef SIMDMA_INIT_CHKSUM_EN
      chk_q      <= chk_d;
`endif
    end
  end

  assign rom_addr = {1'b0, idx_q[12:0], 2'b00};
  assign wr_valid = wr_valid_q;
  assign wr_addr  = wr_addr_q;
  assign wr_data  = wr_data_q;
  assign busy     = busy_q;
  assign done     = done_q;
  assign err      = err_q;

endmodule

// File: doc/simdma_init_seq.md
SIMDMA_INIT_SEQ -- requirements
Module: simdma_init_seq

Interface
REQ-001 gclk  input  iu_clk_type  Block clock; all state on gclk.clk rising edge.
REQ-002 rst  input  1  Reset, asynchronous, active-high.
REQ-003 start  input  1  Single-cycle pulse; begins ROM walk from word 0 when idle.
REQ-004 rom_addr  output  16  Init-ROM byte-lane address, {1'b0, word_idx[12:0], 2'b00}.
REQ-005 rom_dout  input  32  Init-ROM data; valid one cycle after rom_addr is presented (no output register).
REQ-006 wr_valid  output  1  Write request valid.
REQ-007 wr_addr  output  32  Write byte address.
REQ-008 wr_data  output  32  Write data.
REQ-009 wr_ready  input  1  Write accepted when wr_valid and wr_ready are both high.
REQ-010 busy  output  1  High from start acceptance until DONE or ERR.
REQ-011 done  output  1  Sticky; stream ended cleanly; cleared on next accepted start.
REQ-012 err  output  1  Sticky; bad opcode, ROM overrun or checksum mismatch; cleared on next accepted start.

Function
REQ-013 ROM stream format: header [31:28] opcode; 0x0 NOP, 0x1 WRITE (count N = [15:0]), 0xF END; all other opcodes are illegal.
REQ-014 WRITE is followed by one base-address word, then N data words; data word k is written to base + 4*k (32-bit wrap, no carry out).
REQ-015 States: IDLE, FETCH, HDR, BASE, DATA, WAIT_WR, CHK, DONE, ERR.
REQ-016 IDLE: word_idx=0; start -> FETCH, set busy, clear done/err; start in any other state is ignored.
REQ-017 FETCH: one bubble cycle while the first ROM read completes -> HDR.
REQ-018 rom_addr advances by one word each cycle a word is consumed; when the next word is needed, it is on rom_dout the cycle the controller samples it (prefetch).
REQ-019 HDR: NOP -> HDR (next word); WRITE -> BASE; END -> CHK if SIMDMA_INIT_CHKSUM_EN else DONE; illegal -> ERR.
REQ-020 BASE: latch base address; N=0 -> HDR; else -> DATA.
REQ-021 DATA: load wr_addr/wr_data, assert wr_valid -> WAIT_WR.
REQ-022 WAIT_WR: wr_valid, wr_addr and wr_data held stable until handshake; on handshake, remaining=0 -> HDR, else next data word is loaded the same cycle, wr_valid stays high (back-to-back, 1 write/cycle at wr_ready=1).
REQ-023 ROM address is not advanced while wr_valid is high and wr_ready is low; the prefetched word is held in an internal register.
REQ-024 Overrun: consuming a word beyond index 8191 without reaching END -> ERR; word_idx does not wrap.
REQ-025 DONE/ERR: drop busy, keep wr_valid low, set sticky flag -> IDLE the following cycle.
REQ-026 Write count N is 16 bits; the internal remaining counter is 16 bits and decrements on each handshake.

Reset
REQ-027 rst asserted at any time: state=IDLE, word_idx=0, rom_addr=0, wr_valid=0, wr_addr=0, wr_data=0, busy=0, done=0, err=0, checksum=0.
REQ-028 rst mid-write drops wr_valid immediately (asynchronously); the pending write is abandoned, not replayed.

Configuration
REQ-029 SIMDMA_INIT_CHKSUM_EN defined: running XOR of every consumed word from word 0 through END inclusive; CHK consumes one more word and compares it -> DONE on match, ERR on mismatch.
REQ-030 SIMDMA_INIT_CHKSUM_EN undefined: no checksum logic; END -> DONE directly; the word after END is never read.

Verification
REQ-031 ROM {0x1000_0002, 0x0000_0100, 0xAAAA_0001, 0xBBBB_0002, 0xF000_0000}, wr_ready=1 -> writes (0x100,0xAAAA0001), (0x104,0xBBBB0002) on consecutive cycles; done=1, err=0.
REQ-032 Same stream, wr_ready low for 3 cycles on the first write -> wr_addr/wr_data stable for 4 cycles, exactly 2 writes, rom_addr frozen during the stall.
REQ-033 ROM {0x0000_0000, 0x7000_0000} -> no writes; err=1, busy=0 two cycles after the bad header is sampled.
REQ-034 ROM with WRITE N=0, then END -> base word consumed, zero writes, done=1; second start mid-run ignored.
REQ-035 rst pulsed during WAIT_WR -> wr_valid=0 in the same cycle, all outputs at reset values; a subsequent start replays from word 0.
REQ-036 SIMDMA_INIT_CHKSUM_EN defined, correct vs. corrupted checksum word after END -> done=1 vs. err=1; with the macro undefined, the same ROM gives done=1 and the word after END is never read.
